// File: rtl/sub_64.sv
// Registered 64-bit two's-complement subtractor with signed-overflow flag.
// Optional unsigned borrow output enabled by defining SUB_64_BORROW_EN.
module sub_64 (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic [63:0] ans,
  output logic        overflow
`ifdef SUB_64_BORROW_EN
  ,
  output logic        borrow
`endif
);

  localparam int unsigned W = 64;

  logic [W-1:0] nb;
  logic [W-1:0] sum;
  logic [W:0]   carry;
  logic         ovf;

  // Ripple chain of full-adder slices computing a + ~b + 1
  always_comb begin
    nb       = ~b;
    sum      = '0;
    carry    = '0;
    carry[0] = 1'b1;
    for (int unsigned i = 0; i < W; i++) begin
      sum[i]     = a[i] ^ nb[i] ^ carry[i];
      carry[i+1] = (a[i] & nb[i]) | (carry[i] & (a[i] ^ nb[i]));
    end
    ovf = carry[W-1] ^ carry[W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ans      <= '0;
      overflow <= 1'b0;
    end else begin
      ans      <= sum;
      overflow <= ovf;
    end
  end

`ifdef SUB_64_BORROW_EN
  // Borrow is the inverted carry-out: set when unsigned a < unsigned b
  always_ff @(posedge clk) begin
    if (rst) begin
      borrow <= 1'b0;
    end else begin
      borrow <= ~carry[W];
    end
  end
`endif

endmodule

// File: tb/tb_sub_64.sv
// Self-checking bench for sub_64: directed boundary cases plus random pairs
// against an arithmetic reference model.
module tb_sub_64;

  logic        clk;
  logic        rst;
  logic [63:0] a;
  logic [63:0] b;
  logic [63:0] ans;
  logic        overflow;
`ifdef SUB_64_BORROW_EN
  logic        borrow;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  sub_64 dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .ans      (ans),
    .overflow (overflow)
`ifdef SUB_64_BORROW_EN
    ,
    .borrow   (borrow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check64(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check1(input string tag, input logic got, input logic exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  // Reference: exact signed difference in 65 bits, then wrap and range-check
  task automatic model(input logic [63:0] x, input logic [63:0] y, input logic r,
                       output logic [63:0] e_ans, output logic e_ovf, output logic e_brw);
    logic signed [64:0] diff;
    diff = $signed({x[63], x}) - $signed({y[63], y});
    if (r) begin
      e_ans = '0;
      e_ovf = 1'b0;
      e_brw = 1'b0;
    end else begin
      e_ans = diff[63:0];
      e_ovf = (diff > 65'sh0_7FFF_FFFF_FFFF_FFFF) || (diff < -65'sh0_8000_0000_0000_0000);
      e_brw = (x < y);
    end
  endtask

  // Drive one operation, clock it, then check the registered result
  task automatic step(input string tag, input logic [63:0] x, input logic [63:0] y, input logic r);
    logic [63:0] e_ans;
    logic        e_ovf;
    logic        e_brw;
    model(x, y, r, e_ans, e_ovf, e_brw);
    a   = x;
    b   = y;
    rst = r;
    @(posedge clk);
    #1;
    check64({tag, ".ans"}, ans, e_ans);
    check1({tag, ".ovf"}, overflow, e_ovf);
`ifdef SUB_64_BORROW_EN
    check1({tag, ".borrow"}, borrow, e_brw);
`endif
  endtask

  task automatic step_exp(input string tag, input logic [63:0] x, input logic [63:0] y,
                          input logic [63:0] x_ans, input logic x_ovf);
    a   = x;
    b   = y;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check64({tag, ".ans_const"}, ans, x_ans);
    check1({tag, ".ovf_const"}, overflow, x_ovf);
  endtask

  initial begin
    logic [63:0] ra;
    logic [63:0] rb;
    logic [63:0] held;
    logic [63:0] corner [6];
    corner[0] = 64'h0;
    corner[1] = 64'h1;
    corner[2] = 64'hFFFF_FFFF_FFFF_FFFF;
    corner[3] = 64'h7FFF_FFFF_FFFF_FFFF;
    corner[4] = 64'h8000_0000_0000_0000;
    corner[5] = 64'h8000_0000_0000_0001;

    rst = 1'b1;
    a   = 64'd5;
    b   = 64'd3;
    @(posedge clk);
    #1;
    step("reset_hold", 64'd5, 64'd3, 1'b1);
    step_exp("after_reset", 64'd5, 64'd3, 64'd2, 1'b0);

    // Directed cases with hand-derived expected values
    step_exp("mixed", 64'd587619328768, 64'd9923145637281, -64'sd9335526308513, 1'b0);
    step_exp("zero", 64'd0, 64'd0, 64'd0, 1'b0);
    step_exp("near_min1", 64'h8000_0000_0000_0002, 64'd1, 64'h8000_0000_0000_0001, 1'b0);
    step_exp("near_min2", 64'h8000_0000_0000_0002, 64'd2, 64'h8000_0000_0000_0000, 1'b0);
    step_exp("pos_ovf", 64'h7FFF_FFFF_FFFF_FFFE, -64'sd2, 64'h8000_0000_0000_0000, 1'b1);
    step_exp("neg_ovf", 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
    step_exp("a_eq_b", 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 64'd0, 1'b0);
    step_exp("b_min", 64'd7, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0007, 1'b1);
    step_exp("minus1", 64'd1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
`ifdef SUB_64_BORROW_EN
    check1("minus1.borrow_const", borrow, 1'b1);
`endif

    // rst raised between edges must not affect outputs until the next edge
    held = ans;
    a    = 64'd100;
    b    = 64'd1;
    rst  = 1'b1;
    #2;
    check64("async_rst.ans", ans, held);

    // Back-to-back stream with a reset slot in the middle
    step("b2b0", 64'd100, 64'd1, 1'b1);
    step("b2b1", 64'd10, 64'd20, 1'b0);
    step("b2b2", 64'd30, 64'd5, 1'b0);
    step("b2b3", 64'hFFFF, 64'h1, 1'b1);
    step("b2b4", 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0);

    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 6; j++)
        step("corner", corner[i], corner[j], 1'b0);

    for (int i = 0; i < 1000; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) rb = ra;
      if ($urandom_range(0, 7) == 0) ra = corner[$urandom_range(0, 5)];
      if ($urandom_range(0, 7) == 0) rb = corner[$urandom_range(0, 5)];
      step("rand", ra, rb, ($urandom_range(0, 49) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
